// File: rtl/spi_keys.sv
// spi_keys: free-running SPI (mode 0) transmitter of a key-matrix snapshot.
// Each frame is a header byte 0xA5, ceil(NUM_KEYS/8) key bytes (key byte 0
// first, MSB first, unused high bits zero) and a CRC-8/0x07 over the key
// bytes. Frames are separated by an idle gap of GAP_CYCLES clocks.
module spi_keys #(
    parameter int NUM_KEYS   = 61,
    parameter int CLK_DIV    = 2,
    parameter int GAP_CYCLES = 64
) (
    input  logic                clk_g_i,
    input  logic                rstn_g_i,
    input  logic [NUM_KEYS-1:0] keys_i_g,
    output logic                spi_clk_g_o,
    output logic                spi_mosi_g_o
);

    // Frame geometry
    localparam int NB         = (NUM_KEYS + 7) / 8;
    localparam int KEY_W      = 8 * NB;
    localparam int FRAME_W    = KEY_W + 8;        // header + key bytes
    localparam int TOTAL_BITS = FRAME_W + 8;      // plus the CRC byte
    localparam int BIT_W      = $clog2(TOTAL_BITS);
    localparam int GAP_W      = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [7:0]       HEADER        = 8'hA5;
    localparam logic [7:0]       CRC_POLY      = 8'h07;
    localparam logic [BIT_W-1:0] FIRST_KEY_BIT = BIT_W'(8);
    localparam logic [BIT_W-1:0] FIRST_CRC_BIT = BIT_W'(FRAME_W);
    localparam logic [BIT_W-1:0] LAST_BIT      = BIT_W'(TOTAL_BITS - 1);
    localparam logic [GAP_W-1:0] GAP_LAST      = GAP_W'(GAP_CYCLES - 1);
    localparam logic [DIV_W-1:0] DIV_LAST      = DIV_W'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        ST_GAP,
        ST_LOAD,
        ST_SHIFT
    } state_t;

    // One serial CRC-8 step (poly 0x07, MSB first)
    function automatic logic [7:0] crc_step(input logic [7:0] crc, input logic din);
        logic fb;
        fb = crc[7] ^ din;
        return {crc[6:0], 1'b0} ^ (fb ? CRC_POLY : 8'h00);
    endfunction

    // ------------------------------------------------------------------
    // Key synchronizers
    // ------------------------------------------------------------------
    logic [NUM_KEYS-1:0] sync_meta_reg;
    logic [NUM_KEYS-1:0] sync_reg;

    // Two-flop synchronizer on every key input
    always_ff @(posedge clk_g_i or negedge rstn_g_i) begin
        if (!rstn_g_i) begin
            sync_meta_reg <= '0;
            sync_reg      <= '0;
        end else begin
            sync_meta_reg <= keys_i_g;
            sync_reg      <= sync_meta_reg;
        end
    end

    // ------------------------------------------------------------------
    // Key byte arrangement: pad to whole bytes, key byte 0 transmitted first
    // ------------------------------------------------------------------
    logic [KEY_W-1:0] keys_padded;   // bit j = key j, zero above NUM_KEYS
    logic [KEY_W-1:0] key_bytes;     // key byte 0 in the top byte

    generate
        for (genvar gi = 0; gi < KEY_W; gi++) begin : g_pad
            if (gi < NUM_KEYS) begin : g_key
                assign keys_padded[gi] = sync_reg[gi];
            end else begin : g_zero
                assign keys_padded[gi] = 1'b0;
            end
        end
        for (genvar gi = 0; gi < NB; gi++) begin : g_order
            assign key_bytes[KEY_W-1-8*gi -: 8] = keys_padded[8*gi +: 8];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Transmitter state
    // ------------------------------------------------------------------
    state_t             state_reg,   state_next;
    logic [GAP_W-1:0]   gap_cnt_reg, gap_cnt_next;
    logic [DIV_W-1:0]   div_cnt_reg, div_cnt_next;
    logic [BIT_W-1:0]   bit_cnt_reg, bit_cnt_next;
    logic [FRAME_W-1:0] frame_reg,   frame_next;
    logic [7:0]         crc_reg,     crc_next;
    logic               sclk_reg,    sclk_next;
    logic               mosi_reg,    mosi_next;
    logic [BIT_W-1:0]   launch_idx;

    // State and datapath registers; reset aborts any frame in progress
    always_ff @(posedge clk_g_i or negedge rstn_g_i) begin
        if (!rstn_g_i) begin
            state_reg   <= ST_GAP;
            gap_cnt_reg <= '0;
            div_cnt_reg <= '0;
            bit_cnt_reg <= '0;
            frame_reg   <= '0;
            crc_reg     <= '0;
            sclk_reg    <= 1'b0;
            mosi_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            gap_cnt_reg <= gap_cnt_next;
            div_cnt_reg <= div_cnt_next;
            bit_cnt_reg <= bit_cnt_next;
            frame_reg   <= frame_next;
            crc_reg     <= crc_next;
            sclk_reg    <= sclk_next;
            mosi_reg    <= mosi_next;
        end
    end

    // Next-state logic: gap timing, snapshot load, bit timing and bit launch
    always_comb begin
        state_next   = state_reg;
        gap_cnt_next = gap_cnt_reg;
        div_cnt_next = div_cnt_reg;
        bit_cnt_next = bit_cnt_reg;
        frame_next   = frame_reg;
        crc_next     = crc_reg;
        sclk_next    = sclk_reg;
        mosi_next    = mosi_reg;
        launch_idx   = bit_cnt_reg + 1'b1;

        case (state_reg)
            ST_GAP: begin
                sclk_next = 1'b0;
                mosi_next = 1'b0;
                if (gap_cnt_reg == GAP_LAST) begin
                    gap_cnt_next = '0;
                    state_next   = ST_LOAD;
                end else begin
                    gap_cnt_next = gap_cnt_reg + 1'b1;
                end
            end

            ST_LOAD: begin
                // Header MSB goes out on the first SHIFT cycle; the frame
                // register keeps the remaining header bits and the snapshot.
                frame_next   = {HEADER[6:0], key_bytes, 1'b0};
                mosi_next    = HEADER[7];
                sclk_next    = 1'b0;
                crc_next     = 8'h00;
                bit_cnt_next = '0;
                div_cnt_next = '0;
                state_next   = ST_SHIFT;
            end

            ST_SHIFT: begin
                if (div_cnt_reg != DIV_LAST) begin
                    div_cnt_next = div_cnt_reg + 1'b1;
                end else begin
                    div_cnt_next = '0;
                    if (!sclk_reg) begin
                        // end of low phase: receiver samples on this rise
                        sclk_next = 1'b1;
                    end else begin
                        sclk_next = 1'b0;
                        if (bit_cnt_reg == LAST_BIT) begin
                            mosi_next    = 1'b0;
                            gap_cnt_next = '0;
                            state_next   = ST_GAP;
                        end else begin
                            bit_cnt_next = launch_idx;
                            if (launch_idx < FIRST_CRC_BIT) begin
                                mosi_next  = frame_reg[FRAME_W-1];
                                frame_next = {frame_reg[FRAME_W-2:0], 1'b0};
                                // header bits are excluded from the CRC
                                if (launch_idx >= FIRST_KEY_BIT) begin
                                    crc_next = crc_step(crc_reg, frame_reg[FRAME_W-1]);
                                end
                            end else begin
                                // CRC is final here; shift it out MSB first
                                mosi_next = crc_reg[7];
                                crc_next  = {crc_reg[6:0], 1'b0};
                            end
                        end
                    end
                end
            end

            default: begin
                state_next = ST_GAP;
            end
        endcase
    end

    assign spi_clk_g_o  = sclk_reg;
    assign spi_mosi_g_o = mosi_reg;

endmodule

// File: tb/tb_spi_keys.sv
// tb_spi_keys: directed test of spi_keys with default parameters.
// A monitor decodes frames on rising spi_clk edges and tracks protocol
// timing; the main sequence compares decoded frames to hand-built values.
module tb_spi_keys;

    localparam int NUM_KEYS = 61;
    localparam int CLK_DIV  = 2;
    localparam int GAP      = 64;
    localparam int FBITS    = 80;

    logic                clk;
    logic                rst_n;
    logic [NUM_KEYS-1:0] keys;
    logic                spi_clk;
    logic                spi_mosi;

    spi_keys #(
        .NUM_KEYS   (NUM_KEYS),
        .CLK_DIV    (CLK_DIV),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk_g_i      (clk),
        .rstn_g_i     (rst_n),
        .keys_i_g     (keys),
        .spi_clk_g_o  (spi_clk),
        .spi_mosi_g_o (spi_mosi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    // clock edges seen since the last reset release
    int rel_cnt = 0;
    always @(posedge clk) begin
        if (!rst_n) rel_cnt = 0;
        else        rel_cnt = rel_cnt + 1;
    end

    // frame decoder and timing monitor, sampled on the falling edge
    logic [FBITS-1:0] frames[$];
    int               starts[$];
    logic [FBITS-1:0] cur = '0;
    int               nbits = 0;
    int               start_cyc = 0;
    int               high_len = 0;
    int               low_len = 0;
    int               proto_err = 0;
    logic             prev_sclk = 1'b0;
    logic             prev_mosi = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            nbits     = 0;
            high_len  = 0;
            low_len   = 0;
            prev_sclk = 1'b0;
            prev_mosi = 1'b0;
        end else begin
            if (spi_clk) begin
                if (!prev_sclk) begin
                    if (nbits != 0 && low_len != CLK_DIV) proto_err++;
                    if (nbits == 0) start_cyc = rel_cnt;
                    cur = {cur[FBITS-2:0], spi_mosi};
                    nbits++;
                    if (nbits == FBITS) begin
                        frames.push_back(cur);
                        starts.push_back(start_cyc);
                        nbits = 0;
                    end
                    high_len = 1;
                end else begin
                    high_len++;
                    if (spi_mosi !== prev_mosi) proto_err++;
                end
            end else begin
                if (prev_sclk) begin
                    if (high_len != CLK_DIV) proto_err++;
                    low_len = 1;
                end else begin
                    low_len++;
                end
            end
            prev_sclk = spi_clk;
            prev_mosi = spi_mosi;
        end
    end

    function automatic logic [FBITS-1:0] frame_at(input int i);
        if (i < frames.size()) return frames[i];
        return 'x;
    endfunction

    function automatic int start_at(input int i);
        if (i < starts.size()) return starts[i];
        return -100000;
    endfunction

    // reference CRC-8/0x07 over 8 bytes, first byte in the top bits
    function automatic logic [7:0] crc8_bytes(input logic [63:0] data);
        logic [7:0] c;
        logic       fb;
        c = 8'h00;
        for (int i = 63; i >= 0; i--) begin
            fb = c[7] ^ data[i];
            c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return c;
    endfunction

    task automatic check(input string tag, input logic [FBITS-1:0] got, input logic [FBITS-1:0] exp);
        checks++;
        assert (got === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, got, exp);
    endtask

    task automatic wait_frames(input int n);
        for (int i = 0; i < 1500 && frames.size() < n; i++) @(negedge clk);
        check($sformatf("frame_count_%0d", n), FBITS'(frames.size() >= n), FBITS'(1));
    endtask

    localparam logic [FBITS-1:0] F_ZERO  = 80'hA5_00_00_00_00_00_00_00_00_00;
    localparam logic [FBITS-1:0] F_KEY60 = 80'hA5_00_00_00_00_00_00_00_10_70;

    logic [63:0]      kb_all;
    logic [63:0]      kb_rnd;
    logic [FBITS-1:0] f_all;
    logic [FBITS-1:0] f_rnd;

    initial begin
        // key byte 0 is sent first, so byte order is reversed from keys
        kb_all = 64'hFF_FF_FF_FF_FF_FF_FF_1F;
        kb_rnd = 64'hEF_CD_AB_89_67_45_23_01;  // keys = 61'h0123456789ABCDEF
        f_all  = {8'hA5, kb_all, crc8_bytes(kb_all)};
        f_rnd  = {8'hA5, kb_rnd, crc8_bytes(kb_rnd)};

        rst_n = 1'b0;
        keys  = '0;
        repeat (3) @(negedge clk);
        check("reset_sclk", FBITS'(spi_clk), FBITS'(0));
        check("reset_mosi", FBITS'(spi_mosi), FBITS'(0));
        #2 rst_n = 1'b1;

        // idle keys: first rise timing, contents and frame period
        wait_frames(1);
        check("first_rise_cycle", FBITS'(start_at(0)), FBITS'(GAP + 1 + CLK_DIV));
        check("frame0_zero", frame_at(0), F_ZERO);
        wait_frames(2);
        check("frame1_zero", frame_at(1), F_ZERO);
        check("period_0_1", FBITS'(start_at(1) - start_at(0)), FBITS'(385));

        // single key at the top bit position
        keys = 61'h1 << 60;
        wait_frames(3);
        check("frame2_key60", frame_at(2), F_KEY60);
        check("period_1_2", FBITS'(start_at(2) - start_at(1)), FBITS'(385));

        // every key pressed; padding bits must stay zero
        keys = '1;
        wait_frames(4);
        check("frame3_all", frame_at(3), f_all);

        // change keys in the middle of a frame
        keys = '0;
        for (int i = 0; i < 1000 && !(frames.size() == 4 && nbits >= 20); i++) @(negedge clk);
        check("mid_shift_reached", FBITS'(frames.size() == 4 && nbits >= 20), FBITS'(1));
        keys = 61'h0123_4567_89AB_CDEF;
        wait_frames(5);
        check("frame4_old_snapshot", frame_at(4), F_ZERO);
        wait_frames(6);
        check("frame5_new_snapshot", frame_at(5), f_rnd);

        // reset while spi_clk and mosi are both high mid-frame
        for (int i = 0; i < 1000 && !(frames.size() == 6 && nbits >= 30 && spi_clk && spi_mosi); i++)
            @(negedge clk);
        check("mid_frame_high_found", FBITS'(spi_clk && spi_mosi), FBITS'(1));
        #2 rst_n = 1'b0;
        #1;
        check("abort_sclk", FBITS'(spi_clk), FBITS'(0));
        check("abort_mosi", FBITS'(spi_mosi), FBITS'(0));
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        wait_frames(7);
        check("restart_rise_cycle", FBITS'(start_at(6)), FBITS'(67));
        check("restart_frame", frame_at(6), f_rnd);
        wait_frames(8);
        check("restart_period", FBITS'(start_at(7) - start_at(6)), FBITS'(385));

        check("protocol_timing", FBITS'(proto_err), FBITS'(0));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
